// File: rtl/console_capture.sv
// ---------------------------------------------------------------------------
// console_capture
//
// Captures the CPU console channel (out_byte / out_byte_en / trap) into a
// first-word-fall-through FIFO and drains it over a ready/valid stream to a
// host, UART or log sink. Also tracks how many characters were accepted,
// whether any were lost, when the run has trapped and fully drained, and
// whether the CPU has gone silent for too long (watchdog).
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   resetn       asynchronous active-low reset
//   out_byte     character from the CPU
//   out_byte_en  out_byte valid this cycle
//   trap         CPU trap (level)
//   m_valid      head entry available
//   m_data       head entry (0 when the FIFO is empty)
//   m_ready      sink accepts the head entry
//   level        current FIFO occupancy
//   byte_count   characters accepted into the FIFO (wraps)
//   overflow     sticky: a character was dropped on a full FIFO
//   trap_seen    sticky: trap observed
//   done         trap seen and FIFO drained
//   wd_expired   sticky: no accepted character for TIMEOUT cycles
// ---------------------------------------------------------------------------
module console_capture #(
  parameter int DATA_W  = 11,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [DATA_W-1:0]          out_byte,
  input  logic                       out_byte_en,
  input  logic                       trap,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           byte_count,
  output logic                       overflow,
  output logic                       trap_seen,
  output logic                       done,
  output logic                       wd_expired
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // -------------------------------------------------------------------------
  // Run-state machine
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_HUNG  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // -------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [CNT_W-1:0] byte_count_reg;
  logic             overflow_reg;
  logic             trap_seen_reg;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic wr_en;
  logic drop;
  logic wd_fire;

  assign fifo_full  = (level_reg == LVL_W'(DEPTH));
  assign fifo_empty = (level_reg == '0);

  // Once the trap has been registered the CPU output is ignored entirely;
  // the character presented on the trap cycle itself still gets in.
  assign push = out_byte_en && !trap_seen_reg;
  assign pop  = m_valid && m_ready;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!fifo_full || pop);
  assign drop  = push && fifo_full && !pop;

  always_comb begin
    level_next = level_reg;
    if (wr_en && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (pop && !wr_en) begin
      level_next = level_reg - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      byte_count_reg <= '0;
      overflow_reg   <= 1'b0;
      trap_seen_reg  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg     <= wr_ptr_reg + PTR_W'(1);
        byte_count_reg <= byte_count_reg + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg <= level_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (trap) begin
        trap_seen_reg <= 1'b1;
      end
    end
  end

  // Storage has no reset: clearing the pointers and level is enough to
  // discard the contents, and it keeps the array mappable onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= out_byte;
    end
  end

  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_empty ? '0 : mem[rd_ptr_reg];
  assign level      = level_reg;
  assign byte_count = byte_count_reg;
  assign overflow   = overflow_reg;
  assign trap_seen  = trap_seen_reg;

  // -------------------------------------------------------------------------
  // Watchdog: counts cycles without an accepted character
  // -------------------------------------------------------------------------
  if (TIMEOUT > 0) begin : g_wd
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            wd_exp_reg;
    logic            wd_clear;

    // Trap counts as "activity ended normally", so it also silences the
    // watchdog, including on the very cycle trap is first sampled.
    assign wd_clear = wr_en || trap_seen_reg || trap || wd_exp_reg;
    assign wd_fire  = !wd_clear && (wd_cnt_reg == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        wd_cnt_reg <= '0;
        wd_exp_reg <= 1'b0;
      end else begin
        if (wd_clear) begin
          wd_cnt_reg <= '0;
        end else begin
          wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        end
        if (wd_fire) begin
          wd_exp_reg <= 1'b1;
        end
      end
    end

    assign wd_expired = wd_exp_reg;
  end else begin : g_no_wd
    assign wd_fire    = 1'b0;
    assign wd_expired = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Run-state machine: RUN / HUNG until trap, DRAIN until empty, then DONE.
  // DONE is evaluated on the registered level, so it rises one cycle after
  // the final pop.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (trap) begin
          state_next = ST_DRAIN;
        end else if (wd_fire) begin
          state_next = ST_HUNG;
        end
      end
      ST_HUNG: begin
        if (trap) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_console_capture.sv
// ---------------------------------------------------------------------------
// tb_console_capture
//
// Self-checking bench for console_capture (DATA_W=11, DEPTH=16, TIMEOUT=8).
// A vector table covers streaming and trap capture; hand-written sequences
// cover reset values, overflow, full-with-pop, watchdog timing and an
// asynchronous reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_console_capture;

  localparam int DATA_W  = 11;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              resetn;
  logic [DATA_W-1:0] out_byte;
  logic              out_byte_en;
  logic              trap;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [4:0]        level;
  logic [CNT_W-1:0]  byte_count;
  logic              overflow;
  logic              trap_seen;
  logic              done;
  logic              wd_expired;

  int checks = 0;
  int errors = 0;

  console_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .out_byte   (out_byte),
    .out_byte_en(out_byte_en),
    .trap       (trap),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .level      (level),
    .byte_count (byte_count),
    .overflow   (overflow),
    .trap_seen  (trap_seen),
    .done       (done),
    .wd_expired (wd_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] d;
    logic              trp;
    logic              rdy;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic [4:0]        e_level;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_ovf;
    logic              e_done;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench 1 ns after a rising edge with resetn just released.
  task automatic do_reset();
    out_byte_en = 1'b0;
    out_byte    = '0;
    trap        = 1'b0;
    m_ready     = 1'b0;
    resetn      = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_q [$];

    // rst en  data    trap rdy | valid data    lvl cnt ovf done
    vecs[0] = '{1'b1, 1'b1, 11'h048, 1'b0, 1'b1, 1'b1, 11'h048, 5'd1, 32'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 11'h069, 1'b0, 1'b1, 1'b1, 11'h069, 5'd1, 32'd2, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 11'h00A, 1'b0, 1'b1, 1'b1, 11'h00A, 5'd1, 32'd3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000, 5'd0, 32'd3, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 11'h041, 1'b1, 1'b0, 1'b1, 11'h041, 5'd1, 32'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 11'h042, 1'b1, 1'b0, 1'b1, 11'h041, 5'd1, 32'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000, 5'd0, 32'd1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000, 5'd0, 32'd1, 1'b0, 1'b1};

    resetn      = 1'b1;
    out_byte    = '0;
    out_byte_en = 1'b0;
    trap        = 1'b0;
    m_ready     = 1'b0;

    // ---------------- reset values ----------------
    do_reset();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_count", byte_count, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_trap", 32'(trap_seen), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wd", 32'(wd_expired), 32'd0);
    $display("reset: valid=%0d level=%0d count=%0d", m_valid, level, byte_count);

    // ---------------- vector table ----------------
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) do_reset();
      out_byte_en = vecs[i].en;
      out_byte    = vecs[i].d;
      trap        = vecs[i].trp;
      m_ready     = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
      check($sformatf("vec%0d_count", i), byte_count, vecs[i].e_cnt);
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      $display("vec %0d: en=%0d d=%h trap=%0d rdy=%0d -> valid=%0d data=%h level=%0d count=%0d done=%0d",
               i, vecs[i].en, vecs[i].d, vecs[i].trp, vecs[i].rdy, m_valid, m_data, level, byte_count, done);
    end
    trap = 1'b0;
    check("trap_seen_sticky", 32'(trap_seen), 32'd1);

    // ---------------- overflow: 17 pushes into 16 entries ----------------
    do_reset();
    for (int i = 0; i < 17; i++) begin
      out_byte_en = 1'b1;
      out_byte    = DATA_W'(i);
      step();
    end
    out_byte_en = 1'b0;
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", byte_count, 32'd16);
    $display("overflow fill: level=%0d overflow=%0d count=%0d", level, overflow, byte_count);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_drain%0d", i), 32'(m_data), 32'(i));
      $display("overflow drain %0d: data=%h", i, m_data);
      step();
    end
    check("ovf_empty_level", 32'(level), 32'd0);
    check("ovf_empty_valid", 32'(m_valid), 32'd0);
    check("ovf_still_set", 32'(overflow), 32'd1);

    // ---------------- full FIFO with simultaneous pop ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      out_byte_en = 1'b1;
      out_byte    = DATA_W'(i);
      step();
    end
    out_byte_en = 1'b1;
    out_byte    = 11'h055;
    m_ready     = 1'b1;
    step();
    out_byte_en = 1'b0;
    check("fullpop_level", 32'(level), 32'd16);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_count", byte_count, 32'd17);
    $display("full+pop: level=%0d overflow=%0d count=%0d", level, overflow, byte_count);
    exp_q = {};
    for (int i = 1; i < 16; i++) exp_q.push_back(DATA_W'(i));
    exp_q.push_back(11'h055);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fullpop_drain%0d", i), 32'(m_data), 32'(exp_q[i]));
      $display("full+pop drain %0d: data=%h", i, m_data);
      step();
    end
    check("fullpop_empty", 32'(m_valid), 32'd0);

    // ---------------- watchdog with no pushes ----------------
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("wd_idle_c%0d", k), 32'(wd_expired), 32'(k >= 8));
      $display("watchdog idle cycle %0d: wd_expired=%0d", k, wd_expired);
    end

    // ---------------- watchdog restarted by a push at cycle 5 ----------------
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      out_byte_en = (k == 5);
      out_byte    = 11'h033;
      step();
      check($sformatf("wd_push_c%0d", k), 32'(wd_expired), 32'(k >= 13));
      $display("watchdog push cycle %0d: wd_expired=%0d", k, wd_expired);
    end
    out_byte_en = 1'b0;

    // ---------------- asynchronous reset mid-stream ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      out_byte_en = 1'b1;
      out_byte    = DATA_W'(11'h100 + i);
      step();
    end
    out_byte_en = 1'b0;
    check("ares_level_before", 32'(level), 32'd5);
    #2;
    resetn = 1'b0;
    #1;
    check("ares_level", 32'(level), 32'd0);
    check("ares_valid", 32'(m_valid), 32'd0);
    check("ares_data", 32'(m_data), 32'd0);
    check("ares_count", byte_count, 32'd0);
    check("ares_ovf", 32'(overflow), 32'd0);
    check("ares_wd", 32'(wd_expired), 32'd0);
    $display("async reset: level=%0d valid=%0d count=%0d", level, m_valid, byte_count);
    #2;
    resetn      = 1'b1;
    out_byte_en = 1'b1;
    out_byte    = 11'h07A;
    step();
    out_byte_en = 1'b0;
    check("ares_post_level", 32'(level), 32'd1);
    check("ares_post_data", 32'(m_data), 32'h07A);
    check("ares_post_count", byte_count, 32'd1);
    $display("after async reset push: level=%0d data=%h", level, m_data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_capture.md
Name: console_capture

Overview:
- Synthesizable capture unit for the CPU console channel (out_byte/out_byte_en/trap) of the system top.
- Buffers emitted characters in a parametrised FIFO and drains them over a ready/valid stream to a host, UART or log sink.
- Adds byte counting, sticky overflow, trap-then-drain completion and a no-output watchdog.
- Lets simulation and FPGA builds share one end-of-run mechanism.

Parameters:
- DATA_W, 11, width of out_byte and stream data.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_W, 32, width of byte_count.
- TIMEOUT, 1000000, idle cycles before watchdog fires; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- out_byte  in  DATA_W  character from the CPU.
- out_byte_en  in  1  out_byte valid this cycle.
- trap  in  1  CPU trap (level).
- m_valid  out  1  head entry available.
- m_data  out  DATA_W  head entry.
- m_ready  in  1  sink accepts head.
- level  out  $clog2(DEPTH)+1  current occupancy.
- byte_count  out  CNT_W  characters accepted into the FIFO.
- overflow  out  1  sticky: a character was dropped.
- trap_seen  out  1  sticky: trap observed.
- done  out  1  trap_seen and FIFO empty.
- wd_expired  out  1  sticky watchdog timeout.

Behaviour:
- Reset (resetn low, asynchronous): FIFO empty, level=0, m_valid=0, m_data=0, byte_count=0, overflow=0, trap_seen=0, done=0, wd_expired=0, watchdog counter=0.
- Push condition: out_byte_en && !trap_seen. A character presented in the same cycle trap first rises is accepted. After trap_seen is set, out_byte_en is ignored and is not counted as overflow.
- Pop condition: m_valid && m_ready.
- FIFO is first-word-fall-through:
  - m_valid = (level != 0).
  - m_data = head entry; it is 0 when the FIFO is empty.
  - Write-to-m_valid latency is 1 cycle: a push at edge N gives m_valid high after edge N.
- Full FIFO (level==DEPTH):
  - With a simultaneous pop, the push is accepted and level stays DEPTH.
  - Without a pop, the character is dropped, overflow sets and stays set until reset, and byte_count does not increment.
- Empty FIFO with push and m_ready both high: no pop occurs, because m_valid was low. The push lands and level becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately, so full and empty are unambiguous.
- byte_count increments by 1 per accepted push and wraps at 2^CNT_W.
- trap_seen sets on the first cycle trap is sampled high and holds until reset.
- done is registered: done = trap_seen && level==0 && !push, and goes high 1 cycle after the last pop following the trap.
- Watchdog (TIMEOUT>0):
  - Counter clears on an accepted push, on trap_seen, or while wd_expired is high; otherwise it increments.
  - When counter==TIMEOUT-1 while incrementing, wd_expired sets next edge and holds until reset.
  - Counting starts at reset release.
  - The counter width is sized to hold TIMEOUT.
- Watchdog (TIMEOUT==0): wd_expired is constant 0.
- State summary, implemented as a 2-bit FSM:
  - RUN: initial state.
  - RUN -> DRAIN on trap.
  - DRAIN -> DONE when the FIFO is empty.
  - RUN -> HUNG on watchdog expiry.
  - HUNG -> DRAIN on trap (wd_expired stays set).
  - DONE is terminal until reset.
- Reset asserted mid-operation aborts immediately. Contents are discarded and all state returns to the reset values, independent of clk.

Test Plan:
- Stream "Hi\n" (0x48,0x69,0x0A) with m_ready=1: m_data sequence 0x48,0x69,0x0A, each visible 1 cycle after push; byte_count=3; overflow=0.
- DEPTH=16, m_ready=0, push 17 bytes 0x00..0x10: level=16, overflow=1, byte_count=16. Then m_ready=1: 0x00..0x0F drained in order, 0x10 absent.
- FIFO full and m_ready=1 while pushing 0x55: push accepted, level stays 16, overflow stays 0, 0x55 emerges last.
- Push 0x41 in the same cycle trap rises, then push 0x42 while trap is high: only 0x41 is captured; byte_count=1. done rises 1 cycle after 0x41 is popped.
- TIMEOUT=8, no pushes after reset: wd_expired high exactly 8 cycles after reset release. Repeat with a push at cycle 5: wd_expired high at cycle 13.
- Pulse resetn low for 3 ns mid-stream with 5 entries queued: all outputs return to 0 asynchronously, before the next clk edge, and a subsequent push gives level=1.
